// File: rtl/psum_glb_drain_if.sv
// Bundle of the drain engine's control, PSUM GLB port-A and output-FIFO signals.
// The engine side uses master; the controller/GLB/FIFO environment uses slave.
interface psum_glb_drain_if #(
    parameter int FIFO_WIDTH     = 64,
    parameter int PSUM_GLB_DEPTH = 16
);
    localparam int ADDR_WIDTH = $clog2(PSUM_GLB_DEPTH);

    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   num_words;
    logic                  busy;
    logic                  done;
    logic                  re_a_psum;
    logic [ADDR_WIDTH-1:0] addr_a_psum;
    logic [FIFO_WIDTH-1:0] rdata_a_psum;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [FIFO_WIDTH-1:0] fifo_wdata;

    modport master (
        input  start, base_addr, num_words, rdata_a_psum, fifo_full,
        output busy, done, re_a_psum, addr_a_psum, fifo_wr_en, fifo_wdata
    );

    modport slave (
        output start, base_addr, num_words, rdata_a_psum, fifo_full,
        input  busy, done, re_a_psum, addr_a_psum, fifo_wr_en, fifo_wdata
    );
endinterface

// File: rtl/psum_glb_drain.sv
// Streams a programmed run of packed words from PSUM GLB port A into the output FIFO,
// absorbing FIFO backpressure in a 2-entry hold buffer so no word is lost or duplicated.
module psum_glb_drain #(
    parameter int FIFO_WIDTH     = 64,
    parameter int DATA_WIDTH     = 16,
    parameter int PSUM_GLB_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    psum_glb_drain_if.master bus
);
    localparam int PACK       = FIFO_WIDTH / DATA_WIDTH;
    localparam int ADDR_WIDTH = $clog2(PSUM_GLB_DEPTH);

    localparam logic [ADDR_WIDTH:0] PACK_STEP = (ADDR_WIDTH+1)'(PACK);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(PSUM_GLB_DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH:0]   issue_cnt_reg;
    logic [ADDR_WIDTH:0]   out_cnt_reg;
    logic                  inflight_reg;
    logic                  zero_run_reg;
    logic [1:0]            hold_cnt_reg;
    logic [1:0]            hold_cnt_next;
    logic [FIFO_WIDTH-1:0] hold_mem_reg  [2];
    logic [FIFO_WIDTH-1:0] hold_mem_next [2];

    logic                  issue;
    logic                  hold_pop;
    logic                  ret_push;
    logic                  last_write;
    logic [ADDR_WIDTH:0]   addr_sum;
    logic [ADDR_WIDTH-1:0] addr_next;

    // Credit check uses only registered occupancy, so a pop this cycle never frees a slot early.
    assign issue = (state_reg == RUN) && (issue_cnt_reg != '0) &&
                   ((hold_cnt_reg + {1'b0, inflight_reg}) < 2'd2);

    assign bus.fifo_wr_en = !bus.fifo_full && ((hold_cnt_reg != 2'd0) || inflight_reg);
    assign bus.fifo_wdata = (hold_cnt_reg != 2'd0) ? hold_mem_reg[0] : bus.rdata_a_psum;

    assign hold_pop   = bus.fifo_wr_en && (hold_cnt_reg != 2'd0);
    assign ret_push   = inflight_reg && !(bus.fifo_wr_en && (hold_cnt_reg == 2'd0));
    assign last_write = (state_reg == DRAIN) && bus.fifo_wr_en && (out_cnt_reg == CNT_ONE);

    // A zero-length run reports completion from the DONE cycle itself.
    assign bus.done        = last_write || ((state_reg == DONE) && zero_run_reg);
    assign bus.busy        = (state_reg != IDLE);
    assign bus.re_a_psum   = issue;
    assign bus.addr_a_psum = addr_reg;

    assign addr_sum  = {1'b0, addr_reg} + PACK_STEP;
    assign addr_next = (addr_sum >= DEPTH_LIM) ? ADDR_WIDTH'(addr_sum - DEPTH_LIM)
                                               : addr_sum[ADDR_WIDTH-1:0];

    // Pop shifts the head out first, then a push lands at the post-pop tail.
    always_comb begin
        hold_mem_next = hold_mem_reg;
        hold_cnt_next = hold_cnt_reg;
        if (hold_pop) begin
            hold_mem_next[0] = hold_mem_reg[1];
            hold_cnt_next    = hold_cnt_reg - 2'd1;
        end
        if (ret_push) begin
            hold_mem_next[hold_cnt_next[0]] = bus.rdata_a_psum;
            hold_cnt_next                   = hold_cnt_next + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            issue_cnt_reg <= '0;
            out_cnt_reg   <= '0;
            inflight_reg  <= 1'b0;
            zero_run_reg  <= 1'b0;
            hold_cnt_reg  <= '0;
            for (int i = 0; i < 2; i++) begin
                hold_mem_reg[i] <= '0;
            end
        end else begin
            inflight_reg <= issue;
            hold_cnt_reg <= hold_cnt_next;
            for (int i = 0; i < 2; i++) begin
                hold_mem_reg[i] <= hold_mem_next[i];
            end
            if (bus.fifo_wr_en) begin
                out_cnt_reg <= out_cnt_reg - CNT_ONE;
            end
            if (issue) begin
                addr_reg      <= addr_next;
                issue_cnt_reg <= issue_cnt_reg - CNT_ONE;
            end
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        addr_reg      <= bus.base_addr;
                        issue_cnt_reg <= bus.num_words;
                        out_cnt_reg   <= bus.num_words;
                        zero_run_reg  <= (bus.num_words == '0);
                        state_reg     <= (bus.num_words == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (issue && (issue_cnt_reg == CNT_ONE)) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_write) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    zero_run_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
